// File: rtl/pixel_pkg.sv
// Shared pixel definitions for the RAW10 camera stream blocks.
package pixel_pkg;

  localparam int PIXEL_BITS = 10;
  typedef logic [PIXEL_BITS-1:0] pixel_t;

  // Output skid buffer depth; enough to cover the RAM's 1-cycle read latency.
  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/ram_inferred.sv
// Simple dual-port RAM: synchronous write, registered synchronous read.
module ram_inferred #(
  parameter int ADDR = 9,
  parameter int DATA = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en_i,
  input  logic [ADDR-1:0] wr_addr_i,
  input  logic [DATA-1:0] wr_data_i,
  input  logic            rd_en_i,
  input  logic [ADDR-1:0] rd_addr_i,
  output logic [DATA-1:0] rd_data_o
);

  logic [DATA-1:0] mem_q [0:(1<<ADDR)-1];
  logic [DATA-1:0] rd_data_q;

  // NOTE: the array has no reset so it maps onto block RAM; the FIFO never
  // reads a location before writing it, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pixel_fifo_ctrl.sv
// First-word-fall-through FIFO for RAW10 pixels: one inferred RAM plus a
// 2-entry output skid buffer that hides the RAM read latency.
module pixel_fifo_ctrl
  import pixel_pkg::*;
#(
  parameter int ADDR = 9,
  parameter int DATA = PIXEL_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [DATA-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [DATA-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ADDR+1:0] level
);

  localparam int PW = ADDR + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR{1'b0}}};

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   ram_cnt;
  logic            rd_pending_q, rd_pending_d;
  logic [1:0]      skid_cnt_q, skid_cnt_d;
  logic [DATA-1:0] skid0_q, skid0_d;
  logic [DATA-1:0] skid1_q, skid1_d;
  logic [ADDR+1:0] level_q, level_d;
  logic            run_q;
  logic            full, push, pop, rd_en;
  logic [2:0]      occ;
  logic [1:0]      slot;
  logic [DATA-1:0] rd_data;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  assign ram_cnt   = wr_ptr_q - rd_ptr_q;
  assign full      = (ram_cnt == DEPTH);
  assign in_ready  = run_q & ~full & ~flush;
  assign push      = in_valid & in_ready;
  assign out_valid = (skid_cnt_q != 2'd0);
  assign out_data  = skid0_q;
  assign pop       = out_valid & out_ready;
  assign level     = level_q;

  // Skid occupancy after this cycle's pop, counting the read already in flight.
  assign occ   = {1'b0, skid_cnt_q} + {2'b00, rd_pending_q} - {2'b00, pop};
  assign rd_en = (ram_cnt != '0) & (occ < 3'(SKID_DEPTH)) & ~flush;

  ram_inferred #(.ADDR(ADDR), .DATA(DATA)) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q[ADDR-1:0]),
    .wr_data_i (in_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_ptr_q[ADDR-1:0]),
    .rd_data_o (rd_data)
  );

  // NOTE: every variable gets its hold value first so no path can infer a latch.
  always_comb begin
    skid0_d      = skid0_q;
    skid1_d      = skid1_q;
    slot         = skid_cnt_q - {1'b0, pop};
    wr_ptr_d     = wr_ptr_q + {{ADDR{1'b0}}, push};
    rd_ptr_d     = rd_ptr_q + {{ADDR{1'b0}}, rd_en};
    rd_pending_d = rd_en;

    if (pop) skid0_d = skid1_q;
    if (rd_pending_q) begin
      if (slot == 2'd0) skid0_d = rd_data;
      else              skid1_d = rd_data;
    end
    skid_cnt_d = slot + {1'b0, rd_pending_q};

    // Flush drops RAM words, the skid and any RAM return still in flight.
    if (flush) begin
      rd_ptr_d     = wr_ptr_q;
      rd_pending_d = 1'b0;
      skid_cnt_d   = 2'd0;
    end

    level_d = {1'b0, wr_ptr_d - rd_ptr_d}
            + {{PW{1'b0}}, rd_pending_d}
            + {{ADDR{1'b0}}, skid_cnt_d};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_pending_q <= 1'b0;
      skid_cnt_q   <= 2'd0;
      skid0_q      <= '0;
      skid1_q      <= '0;
      level_q      <= '0;
      run_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_pending_q <= rd_pending_d;
      skid_cnt_q   <= skid_cnt_d;
      skid0_q      <= skid0_d;
      skid1_q      <= skid1_d;
      level_q      <= level_d;
      run_q        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_fifo_ctrl.sv
// Self-checking bench for pixel_fifo_ctrl: queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_pixel_fifo_ctrl;
  import pixel_pkg::*;

  localparam int ADDR = 9;
  localparam int MAXW = (1 << ADDR) + 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  pixel_t          in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  pixel_t          out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [ADDR+1:0] level;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    pixel_t data;
    int     stamp;
  } ent_t;

  ent_t   mq[$];
  int     cyc = 0;
  bit     alive = 1'b0;
  pixel_t exp_q[$];

  pixel_fifo_ctrl #(.ADDR(ADDR), .DATA(PIXEL_BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a word pushed at edge N is available after edge N+2;
  // the FIFO holds up to 2**ADDR + 2 words; level is simply the word count.
  always @(negedge rst_n) begin
    mq.delete();
    alive = 1'b0;
  end

  always @(negedge clk) begin
    logic exp_ir, exp_ov;
    exp_ir = rst_n && alive && !flush && (mq.size() < MAXW);
    exp_ov = rst_n && (mq.size() != 0) && (cyc >= mq[0].stamp + 2);
    check("in_ready", in_ready, exp_ir);
    check("out_valid", out_valid, exp_ov);
    check("level", level, mq.size());
    if (exp_ov)      check("out_data", out_data, mq[0].data);
    else if (!rst_n) check("out_data_rst", out_data, 0);
    if (rst_n) begin
      cyc++;
      if (flush) mq.delete();
      else begin
        if (exp_ov && out_ready) void'(mq.pop_front());
        if (in_valid && exp_ir) mq.push_back('{in_data, cyc});
      end
      alive = 1'b1;
    end
  end

  task automatic drain(input string name);
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 2000 && exp_q.size() != 0; c++) begin
      if (out_valid) check(name, out_data, exp_q.pop_front());
      step();
    end
    check({name, "_left"}, exp_q.size(), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    int recv, first_c, last_c, max_lvl;

    // 1. reset and first word latency
    repeat (3) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", in_ready, 0);
    step();
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    check("idle_level", level, 0);
    in_valid = 1'b1;
    in_data  = 10'h155;
    step();
    in_valid = 1'b0;
    check("lat_level", level, 1);
    check("lat_e0_valid", out_valid, 0);
    step();
    check("lat_e1_valid", out_valid, 0);
    step();
    check("lat_e2_valid", out_valid, 1);
    check("lat_e2_data", out_data, 10'h155);
    exp_q.push_back(10'h155);
    drain("first_word");

    // 2. streaming at one word per clock
    recv = 0; first_c = -1; last_c = -1; max_lvl = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 1004; c++) begin
      if (out_valid) begin
        check("stream_data", out_data, recv);
        if (first_c < 0) first_c = c;
        last_c = c;
        recv++;
      end
      if (int'(level) > max_lvl) max_lvl = int'(level);
      in_valid = (c < 1000);
      in_data  = pixel_t'(c);
      step();
    end
    in_valid = 1'b0;
    check("stream_count", recv, 1000);
    check("stream_first", first_c, 3);
    check("stream_span", last_c - first_c, 999);
    check("stream_max_level", max_lvl, 3);
    out_ready = 1'b0;

    // 3. fill to capacity, extra pushes ignored, drain in order
    for (int i = 0; i < 520; i++) begin
      in_valid = 1'b1;
      in_data  = pixel_t'(i);
      step();
    end
    in_valid = 1'b0;
    check("fill_level", level, 514);
    check("fill_in_ready", in_ready, 0);
    for (int i = 0; i < 514; i++) exp_q.push_back(pixel_t'(i));
    drain("fill_drain");

    // 4. full with wrapped pointers: simultaneous push+pop refuses the push
    for (int i = 0; i < 520; i++) begin
      in_valid = 1'b1;
      in_data  = pixel_t'(i * 3 + 7);
      step();
    end
    in_valid = 1'b0;
    check("wrap_fill_level", level, 514);
    in_valid  = 1'b1;
    in_data   = 10'h3C3;
    out_ready = 1'b1;
    #1;
    check("full_pushpop_ready", in_ready, 0);
    check("full_head", out_data, 7);
    step();
    out_ready = 1'b0;
    #1;
    check("full_after_pop_level", level, 513);
    check("full_retry_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("full_retry_level", level, 514);
    for (int i = 1; i < 514; i++) exp_q.push_back(pixel_t'(i * 3 + 7));
    exp_q.push_back(10'h3C3);
    drain("wrap_drain");

    // 5a. flush with the skid buffer full
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = pixel_t'(i * 17);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    check("preflush_level", level, 4);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 10'h3FF;
    #1;
    check("flush_in_ready", in_ready, 0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_level", level, 0);
    check("flush_out_valid", out_valid, 0);
    in_valid = 1'b1;
    in_data  = 10'h2AA;
    step();
    in_valid = 1'b0;
    exp_q.push_back(10'h2AA);
    drain("post_flush");

    // 5b. flush while a RAM read is in flight
    in_valid = 1'b1;
    in_data  = 10'h101;
    step();
    in_data  = 10'h102;
    step();
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    check("inflight_flush_level", level, 0);
    check("inflight_flush_valid", out_valid, 0);
    repeat (3) step();
    check("inflight_stale_valid", out_valid, 0);
    in_valid = 1'b1;
    in_data  = 10'h1E5;
    step();
    in_valid = 1'b0;
    exp_q.push_back(10'h1E5);
    drain("post_inflight_flush");

    // 6. async reset between edges
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_data  = pixel_t'(c + 64);
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_level", level, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    in_valid = 1'b0;
    check("arst_rel_ready", in_ready, 1);
    check("arst_rel_level", level, 0);
    for (int c = 0; c < 4; c++) begin
      check("arst_no_stale", out_valid, 0);
      step();
    end
    in_valid = 1'b1;
    in_data  = 10'h0AB;
    step();
    in_valid = 1'b0;
    exp_q.push_back(10'h0AB);
    drain("post_reset");

    // random traffic against the model
    for (int c = 0; c < 20000; c++) begin
      int pr;
      pr = ((c / 2000) % 3 == 0) ? 25 : (((c / 2000) % 3 == 1) ? 50 : 90);
      in_valid  = ($urandom_range(0, 99) < 70);
      in_data   = pixel_t'($urandom);
      out_ready = ($urandom_range(0, 99) < pr);
      flush     = ($urandom_range(0, 499) == 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
